// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns PCF, runs the I-cache request handshake,
// absorbs miss latency and loads the IF/ID register for decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request outstanding at PCF; load IF/ID on a clean hit
// DRAIN | redirect seen mid-miss; finish the old request, then jump
// HOLD  | word returned during a stall; parked in the hold buffer
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] pc_plus4D,
  output logic        ValidD,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IFID_BUBBLE = 2'd0,
    IFID_RDATA  = 2'd1,
    IFID_BUF    = 2'd2
  } ifid_act_t;

  state_t      state_q, state_d;
  ifid_act_t   ifid_act;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, pcd_q, pcp4_q;
  logic        valid_q;
  logic [31:0] pcf_plus4;
  logic [31:0] target_al;

  // Low two bits of the redirect target are dropped so PCF stays word aligned.
  assign target_al = PCTargetE & 32'hFFFF_FFFC;
  assign pcf_plus4 = pcf_q + 32'd4;

  // FSM state register; an outstanding cache transaction is simply abandoned on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state, PC, redirect latch, hold buffer and IF/ID action selection.
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    tgt_d    = tgt_q;
    buf_d    = buf_q;
    ifid_act = IFID_BUBBLE;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (PCSrcE) begin
            pcf_d = target_al;
          end else if (StallF || StallD) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            ifid_act = IFID_RDATA;
            pcf_d    = pcf_plus4;
          end
        end else if (PCSrcE) begin
          tgt_d   = target_al;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A redirect arriving on the completing edge still wins over the latched one.
        if (PCSrcE) tgt_d = target_al;
        if (imem_ready) begin
          pcf_d   = PCSrcE ? target_al : tgt_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = target_al;
          state_d = S_FETCH;
        end else if (!StallF && !StallD) begin
          ifid_act = IFID_BUF;
          pcf_d    = pcf_plus4;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Cache request and busy indication; request is masked while reset is asserted.
  always_comb begin
    imem_req   = rst && (state_q != S_HOLD);
    fetch_busy = ((state_q == S_FETCH) && !imem_ready) || (state_q == S_DRAIN);
  end

  // PC, redirect latch and hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf_q <= RESET_PC;
      tgt_q <= 32'd0;
      buf_q <= 32'd0;
    end else begin
      pcf_q <= pcf_d;
      tgt_q <= tgt_d;
      buf_q <= buf_d;
    end
  end

  // IF/ID register: flush beats stall, stall beats the state-selected load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (FlushD) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!StallD) begin
      unique case (ifid_act)
        IFID_RDATA: begin
          instr_q <= imem_rdata;
          pcd_q   <= pcf_q;
          pcp4_q  <= pcf_plus4;
          valid_q <= 1'b1;
        end
        IFID_BUF: begin
          instr_q <= buf_q;
          pcd_q   <= pcf_q;
          pcp4_q  <= pcf_plus4;
          valid_q <= 1'b1;
        end
        default: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign pc_plus4D = pcp4_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: hits, misses, redirects, stalls, flush, wrap and async reset.
module tb_fetch_cycle;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] InstrD, PCD, pc_plus4D;
  logic        ValidD;
  logic        fetch_busy;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_cycle dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .pc_plus4D  (pc_plus4D),
    .ValidD     (ValidD),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {a[19:0], 12'h093};
  endfunction

  assign imem_rdata = instr_at(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] pc,
                          input logic v);
    chk({tag, ".instr"}, InstrD, i);
    chk({tag, ".pcd"},   PCD, pc);
    chk({tag, ".pcp4"},  pc_plus4D, pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0; imem_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.req",   {31'd0, imem_req}, 32'd0);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.instr", InstrD, NOP);
    chk("rst.pcd",   PCD, 32'h0);
    chk("rst.pcp4",  pc_plus4D, 32'h0);
    chk("rst.valid", {31'd0, ValidD}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel.req", {31'd0, imem_req}, 32'd1);

    // Hits at one instruction per cycle
    tick();
    chk_ifid("hit0", 32'h00A0_0093, 32'h0, 1'b1);
    chk("hit0.addr", imem_addr, 32'h4);
    for (int a = 4; a <= 12; a += 4) begin
      tick();
      chk_ifid("hitN", instr_at(a), a, 1'b1);
      chk("hitN.addr", imem_addr, a + 4);
    end

    // Three-cycle miss at 0x10
    imem_ready = 1'b0;
    #1;
    chk("miss.busy", {31'd0, fetch_busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("miss.addr", imem_addr, 32'h10);
      chk("miss.busy2", {31'd0, fetch_busy}, 32'd1);
      chk("miss.instr", InstrD, NOP);
      chk("miss.valid", {31'd0, ValidD}, 32'd0);
    end
    imem_ready = 1'b1;
    #1;
    chk("miss.done.busy", {31'd0, fetch_busy}, 32'd0);
    tick();
    chk_ifid("miss.done", instr_at(32'h10), 32'h10, 1'b1);
    tick(); tick(); tick();
    chk("pre3.addr", imem_addr, 32'h20);

    // Redirect during a miss at 0x20
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    chk("drain.addr", imem_addr, 32'h20);
    chk("drain.busy", {31'd0, fetch_busy}, 32'd1);
    PCSrcE = 1'b0; PCTargetE = 32'h300;
    tick();
    chk("drain.addr2", imem_addr, 32'h20);
    chk("drain.valid", {31'd0, ValidD}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("drain.tgt", imem_addr, 32'h200);
    chk("drain.disc", {31'd0, ValidD}, 32'd0);
    tick();
    chk_ifid("tgt", instr_at(32'h200), 32'h200, 1'b1);

    // Second redirect on the completing edge of a drain overrides the latched one
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h500;
    tick();
    imem_ready = 1'b1; PCTargetE = 32'h3F;
    tick();
    chk("latest.addr", imem_addr, 32'h3C);
    PCSrcE = 1'b0;
    tick();
    chk_ifid("at3c", instr_at(32'h3C), 32'h3C, 1'b1);
    chk("at3c.addr", imem_addr, 32'h40);

    // Stall on hit at 0x40 for two cycles
    StallF = 1'b1; StallD = 1'b1;
    tick();
    chk("hold.req", {31'd0, imem_req}, 32'd0);
    chk_ifid("hold1", instr_at(32'h3C), 32'h3C, 1'b1);
    tick();
    chk_ifid("hold2", instr_at(32'h3C), 32'h3C, 1'b1);
    chk("hold2.addr", imem_addr, 32'h40);
    StallF = 1'b0; StallD = 1'b0;
    tick();
    chk_ifid("unhold", instr_at(32'h40), 32'h40, 1'b1);
    chk("unhold.req", {31'd0, imem_req}, 32'd1);
    chk("unhold.addr", imem_addr, 32'h44);

    // FlushD beats StallD; PC does not move
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    chk("flush.instr", InstrD, NOP);
    chk("flush.valid", {31'd0, ValidD}, 32'd0);
    chk("flush.pcd", PCD, 32'h40);
    chk("flush.addr", imem_addr, 32'h44);
    FlushD = 1'b0; StallD = 1'b0;
    tick();
    chk_ifid("postflush", instr_at(32'h44), 32'h44, 1'b1);

    // Redirect to the top word, PC+4 wraps to zero
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    PCSrcE = 1'b0;
    tick();
    chk("wrap.pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap.pcp4", pc_plus4D, 32'h0);
    chk("wrap.next", imem_addr, 32'h0);
    tick();
    chk("wrap.fetch4", imem_addr, 32'h4);

    // Async reset in the middle of a miss
    imem_ready = 1'b0;
    tick();
    chk("rmiss.busy", {31'd0, fetch_busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst.req",   {31'd0, imem_req}, 32'd0);
    chk("arst.addr",  imem_addr, 32'h0);
    chk("arst.instr", InstrD, NOP);
    chk("arst.pcd",   PCD, 32'h0);
    chk("arst.pcp4",  pc_plus4D, 32'h0);
    chk("arst.valid", {31'd0, ValidD}, 32'd0);
    #1 rst = 1'b1; imem_ready = 1'b1;
    #1;
    chk("arel.req",  {31'd0, imem_req}, 32'd1);
    chk("arel.addr", imem_addr, 32'h0);
    tick();
    chk_ifid("arel.hit", 32'h00A0_0093, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
